// File: rtl/alu_arbiter_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
// Holds ALU command codes, FSM state encoding and the operation payload struct.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [CMD_W-1:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd1,
        CMD_MUL = 4'd2,
        CMD_DIV = 4'd3,
        CMD_AND = 4'd4,
        CMD_OR  = 4'd5,
        CMD_XOR = 4'd6,
        CMD_BUF = 4'd7
    } alu_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_op_t;

    // Divide with a zero divisor; the ALU itself returns all-ones in that case.
    function automatic logic is_div_zero(alu_op_t op);
        return (op.cmd == CMD_DIV) && (op.b == '0);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response channels of the ALU arbiter.
// rsp_err exists only when ALU_ARB_ERR_EN is defined.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [CMD_W-1:0]  req0_cmd;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [CMD_W-1:0]  req1_cmd;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [RES_W-1:0]  rsp_data;
`ifdef ALU_ARB_ERR_EN
    logic              rsp_err;
`endif

    modport slave (
        input  req0_valid, req0_cmd, req0_a, req0_b,
        input  req1_valid, req1_cmd, req1_a, req1_b,
        input  rsp_ready,
`ifdef ALU_ARB_ERR_EN
        output rsp_err,
`endif
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req0_valid, req0_cmd, req0_a, req0_b,
        output req1_valid, req1_cmd, req1_a, req1_b,
        output rsp_ready,
`ifdef ALU_ARB_ERR_EN
        input  rsp_err,
`endif
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: ptr picks the winner only when both requesters are valid.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = 1'b0;
        if (valid == 2'b11) begin
            gnt_id = ptr;
        end else if (valid[1]) begin
            gnt_id = 1'b1;
        end
        grant = (|valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one tri-state ALU between two requesters: IDLE grants, EXEC drives the ALU, RESP returns.
// Optional divide-by-zero flag on the response when ALU_ARB_ERR_EN is defined.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu_arbiter_if.slave       bus,
    output logic [CMD_W-1:0]   alu_cmd,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic               alu_oe,
    input  logic [RES_W-1:0]   alu_d,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    state_t  state;
    logic    rr_ptr;
    logic    id_q;
    alu_op_t op_q;
    alu_op_t op0;
    alu_op_t op1;
    alu_op_t win;
    logic [1:0] grant;
    logic    gnt_id;
    logic    idle;

    rr_arb2 u_rr_arb2 (
        .valid  ({bus.req1_valid, bus.req0_valid}),
        .ptr    (rr_ptr),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    assign op0  = {bus.req0_cmd, bus.req0_a, bus.req0_b};
    assign op1  = {bus.req1_cmd, bus.req1_a, bus.req1_b};
    assign win  = gnt_id ? op1 : op0;
    assign idle = (state == ST_IDLE);

    // Ready is offered only in IDLE and only to the current winner.
    assign bus.req0_ready = idle & grant[0];
    assign bus.req1_ready = idle & grant[1];

    // ALU operand lines come straight from the latch so they hold between operations.
    assign alu_cmd = op_q.cmd;
    assign alu_a   = op_q.a;
    assign alu_b   = op_q.b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= 1'b0;
            id_q          <= 1'b0;
            op_q          <= '0;
            alu_oe        <= 1'b0;
            busy          <= 1'b0;
            op_count      <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= '0;
`ifdef ALU_ARB_ERR_EN
            bus.rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        op_q   <= win;
                        id_q   <= gnt_id;
                        rr_ptr <= ~gnt_id;
                        alu_oe <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_oe        <= 1'b0;
                    bus.rsp_data  <= alu_d;
                    bus.rsp_id    <= id_q;
                    bus.rsp_valid <= 1'b1;
`ifdef ALU_ARB_ERR_EN
                    bus.rsp_err   <= is_div_zero(op_q);
`endif
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                        op_count      <= op_count + CNT_W'(1);
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    alu_oe        <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: protocol/timing model plus a response scoreboard.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();
    logic [CMD_W-1:0]  alu_cmd;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_oe;
    logic [RES_W-1:0]  alu_d;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    alu_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_cmd  (alu_cmd),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_oe   (alu_oe),
        .alu_d    (alu_d),
        .busy     (busy),
        .op_count (op_count)
    );

    typedef struct {
        logic             id;
        logic [RES_W-1:0] data;
        logic             err;
    } exp_t;

    alu_op_t q0[$];
    alu_op_t q1[$];
    exp_t    sb[$];
    exp_t    rsp_log[$];

    int checks   = 0;
    int failures = 0;

    // Model of the arbiter's observable behaviour
    bit               running  = 0;
    bit               pending  = 0;
    int               age      = 0;
    logic             mptr     = 1'b0;
    logic [CNT_W-1:0] exp_count = '0;
    int               stall    = 0;
    bit               rsp_rand = 0;
    bit               rst_req  = 0;
    bit               rst_now  = 0;
    bit               exp_rv;
    bit               g0;
    bit               g1;
    alu_op_t          cur_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU arithmetic on signed 8-bit operands with a 16-bit result.
    function automatic logic [RES_W-1:0] alu_fn(input logic [CMD_W-1:0] cmd,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic signed [RES_W-1:0] sa;
        logic signed [RES_W-1:0] sbv;
        sa  = {{(RES_W-DATA_W){a[DATA_W-1]}}, a};
        sbv = {{(RES_W-DATA_W){b[DATA_W-1]}}, b};
        case (cmd)
            CMD_ADD: return sa + sbv;
            CMD_SUB: return sa - sbv;
            CMD_MUL: return sa * sbv;
            CMD_DIV: return (b == '0) ? {RES_W{1'b1}} : sa / sbv;
            CMD_AND: return RES_W'(a & b);
            CMD_OR:  return RES_W'(a | b);
            CMD_XOR: return RES_W'(a ^ b);
            CMD_BUF: return sa;
            default: return '0;
        endcase
    endfunction

    function automatic alu_op_t mk_op(input logic [CMD_W-1:0] cmd,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        alu_op_t o;
        o.cmd = cmd;
        o.a   = a;
        o.b   = b;
        return o;
    endfunction

    function automatic alu_op_t rnd_op();
        logic [DATA_W-1:0] b;
        b = ($urandom_range(0, 5) == 0) ? '0 : DATA_W'($urandom);
        return mk_op(CMD_W'($urandom_range(0, 7)), DATA_W'($urandom), b);
    endfunction

    // Tri-state ALU stand-in: a marker value while output enable is low.
    assign alu_d = alu_oe ? alu_fn(alu_cmd, alu_a, alu_b) : RES_W'(16'hDEAD);

    // Stimulus driver and timing model: drives inputs each negedge, checks after settling.
    always @(negedge clk) begin
        if (running) begin
            if (rst_now) begin
                rst_now   = 0;
                rst       = 1'b0;
                pending   = 0;
                mptr      = 1'b0;
                exp_count = '0;
                sb.delete();
            end
            if (pending) age++;

            bus.req0_valid = (q0.size() != 0);
            bus.req0_cmd   = (q0.size() != 0) ? q0[0].cmd : '0;
            bus.req0_a     = (q0.size() != 0) ? q0[0].a   : '0;
            bus.req0_b     = (q0.size() != 0) ? q0[0].b   : '0;
            bus.req1_valid = (q1.size() != 0);
            bus.req1_cmd   = (q1.size() != 0) ? q1[0].cmd : '0;
            bus.req1_a     = (q1.size() != 0) ? q1[0].a   : '0;
            bus.req1_b     = (q1.size() != 0) ? q1[0].b   : '0;

            exp_rv = pending && (age >= 2);
            if (exp_rv && stall > 0) begin
                bus.rsp_ready = 1'b0;
                stall--;
            end else if (rsp_rand) begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.rsp_ready = 1'b1;
            end
            if (rst_req && pending && age == 1) begin
                rst     = 1'b1;
                rst_req = 0;
                rst_now = 1;
            end
            #1;

            chk("rsp_valid", bus.rsp_valid, exp_rv);
            chk("alu_oe", alu_oe, pending && age == 1);
            chk("busy", busy, pending);
            chk("op_count", op_count, exp_count);
            if (pending && age == 1) begin
                chk("alu_cmd", alu_cmd, cur_op.cmd);
                chk("alu_a", alu_a, cur_op.a);
                chk("alu_b", alu_b, cur_op.b);
            end

            g0 = !pending && bus.req0_valid && (!bus.req1_valid || mptr == 1'b0);
            g1 = !pending && bus.req1_valid && (!bus.req0_valid || mptr == 1'b1);
            chk("req0_ready", bus.req0_ready, g0);
            chk("req1_ready", bus.req1_ready, g1);

            if (exp_rv && bus.rsp_ready) begin
                pending   = 0;
                exp_count = exp_count + 1'b1;
            end
            if (g0 || g1) begin
                exp_t e;
                cur_op = g1 ? q1.pop_front() : q0.pop_front();
                e.id   = g1;
                e.data = alu_fn(cur_op.cmd, cur_op.a, cur_op.b);
                e.err  = (cur_op.cmd == CMD_DIV) && (cur_op.b == '0);
                sb.push_back(e);
                mptr    = !g1;
                pending = 1;
                age     = 0;
            end
        end
    end

    // Response monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (running) begin
            #2;
            if (bus.rsp_valid) begin
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    chk("rsp_id", bus.rsp_id, sb[0].id);
                    chk("rsp_data", bus.rsp_data, sb[0].data);
`ifdef ALU_ARB_ERR_EN
                    chk("rsp_err", bus.rsp_err, sb[0].err);
`endif
                    if (bus.rsp_ready) rsp_log.push_back(sb.pop_front());
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || pending || sb.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 2000, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        bus.req0_valid = 1'b0; bus.req0_cmd = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_cmd = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_alu_oe", alu_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op_count", op_count, 16'd0);
        chk("rst_rsp_data", bus.rsp_data, 16'd0);
        chk("rst_alu_a", alu_a, 8'd0);
        rst     = 1'b0;
        running = 1;

        // Both valid from reset, then kept valid: req0 first, then alternation.
        q0.push_back(mk_op(CMD_SUB, 8'd10, 8'd4));
        q1.push_back(mk_op(CMD_MUL, 8'hFD, 8'd4));
        q0.push_back(mk_op(CMD_ADD, 8'd1, 8'd1));
        q1.push_back(mk_op(CMD_ADD, 8'd2, 8'd2));
        drain();
        chk("t2_count", rsp_log.size(), 4);
        if (rsp_log.size() == 4) begin
            chk("t2_first_data", rsp_log[0].data, 16'd6);
            chk("t2_first_id", rsp_log[0].id, 1'b0);
            chk("t2_second_data", rsp_log[1].data, 16'hFFF4);
            chk("t2_second_id", rsp_log[1].id, 1'b1);
            chk("t2_third_id", rsp_log[2].id, 1'b0);
            chk("t2_fourth_id", rsp_log[3].id, 1'b1);
        end

        // Single requester ADD.
        q0.push_back(mk_op(CMD_ADD, 8'd5, 8'd3));
        drain();
        chk("t1_data", rsp_log[$].data, 16'd8);
        chk("t1_id", rsp_log[$].id, 1'b0);

        // Consumer stalls five cycles in RESP.
        stall = 5;
        q1.push_back(mk_op(CMD_XOR, 8'hF0, 8'h3C));
        drain();
        chk("t3_data", rsp_log[$].data, 16'h00CC);
        chk("t3_stall_used", stall, 0);

        // Divide by zero.
        q0.push_back(mk_op(CMD_DIV, 8'd7, 8'd0));
        drain();
        chk("t4_data", rsp_log[$].data, 16'hFFFF);
`ifdef ALU_ARB_ERR_EN
        chk("t4_err", rsp_log[$].err, 1'b1);
`endif

        // Reset during EXEC discards the operation.
        base    = rsp_log.size();
        rst_req = 1;
        q1.push_back(mk_op(CMD_ADD, 8'd9, 8'd9));
        drain();
        chk("t5_no_rsp", rsp_log.size(), base);
        chk("t5_op_count", op_count, 16'd0);
        chk("t5_alu_oe", alu_oe, 1'b0);

        // Counter wrap from all-ones to zero.
        @(posedge clk);
        #2;
        force dut.op_count = CNT_W'(16'hFFFE);
        #1;
        release dut.op_count;
        exp_count = CNT_W'(16'hFFFE);
        q0.push_back(mk_op(CMD_BUF, 8'd1, 8'd0));
        q0.push_back(mk_op(CMD_OR, 8'd1, 8'd2));
        drain();
        chk("t6_wrap", op_count, 16'd0);

        // Randomised traffic with random consumer back-pressure.
        rsp_rand = 1;
        for (int i = 0; i < 60; i++) begin
            int sel;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sel = $urandom_range(0, 2);
            if (sel != 1) q0.push_back(rnd_op());
            if (sel != 0) q1.push_back(rnd_op());
        end
        drain();
        chk("rand_final_count", op_count, exp_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
